// File: rtl/t02_pkg.sv
// Shared types for the memory arbiter: FSM states, grant owner, latched bus command.
package t02_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  localparam logic [3:0] SEL_WORD = 4'hF;

  // Everything driven onto the bus for one transaction, captured at grant time
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
  } bus_cmd_t;

  // Fetches are always full-word reads
  function automatic bus_cmd_t fetch_cmd(input logic [31:0] addr);
    bus_cmd_t c;
    c.addr  = addr;
    c.wdata = '0;
    c.sel   = SEL_WORD;
    c.we    = 1'b0;
    return c;
  endfunction

  function automatic bus_cmd_t data_cmd(input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] sel, input logic we);
    bus_cmd_t c;
    c.addr  = addr;
    c.wdata = wdata;
    c.sel   = sel;
    c.we    = we;
    return c;
  endfunction

endpackage

// File: rtl/t02_bus_timer.sv
// Counts BUSY cycles; expired is high in the last allowed cycle of a transaction.
module t02_bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Restart on every new grant, count while the bus cycle is open, saturate at LAST
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && (count != LAST))
      count <= count + CW'(1);
  end

  // The cycle with count == TIMEOUT-1 is the last one; a bus_ack in it still wins upstream
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/t02_mem_arbiter.sv
// Single-port memory arbiter: data load/store has priority over instruction fetch,
// one bus transaction at a time, registered read data and one-cycle acknowledges.
module t02_mem_arbiter
  import t02_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ack,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_sel,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic        bus_err
);

  arb_state_t  state, state_nxt;
  grant_t      gnt;
  bus_cmd_t    cmd;
  logic [31:0] imem_rdata_q, dmem_rdata_q;
  logic        err_q;

  logic        illegal, grant_d, grant_i;
  logic        done_ok, done_to, expired;
  logic [31:0] done_data;

  // Decisions made in IDLE; data beats fetch, read+write together is rejected
  assign illegal = (state == IDLE) && dmem_read && dmem_write;
  assign grant_d = (state == IDLE) && (dmem_read ^ dmem_write);
  assign grant_i = (state == IDLE) && !dmem_read && !dmem_write && imem_req;

  // Completion in BUSY: an ack in the expiring cycle counts as success
  assign done_ok   = (state == BUSY) && bus_ack;
  assign done_to   = (state == BUSY) && !bus_ack && expired;
  assign done_data = (done_ok && !cmd.we) ? bus_rdata : 32'h0;

  t02_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_d || grant_i),
    .enable  (state == BUSY),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; RESP never grants so the requester can drop its level request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (illegal)                  state_nxt = RESP;
        else if (grant_d || grant_i)  state_nxt = BUSY;
      end
      BUSY: if (done_ok || done_to)   state_nxt = RESP;
      RESP:                           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    bus_req  = (state == BUSY);
    imem_ack = (state == RESP) && (gnt == GNT_I);
    dmem_ack = (state == RESP) && (gnt == GNT_D);
  end

  // Latch the winning command, capture read data on completion, raise the error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= GNT_NONE;
      cmd          <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (illegal) begin
        gnt          <= GNT_D;
        dmem_rdata_q <= '0;
        err_q        <= 1'b1;
      end else if (grant_d) begin
        gnt <= GNT_D;
        cmd <= data_cmd(dmem_addr, dmem_wdata, dmem_sel, dmem_write);
      end else if (grant_i) begin
        gnt <= GNT_I;
        cmd <= fetch_cmd(imem_addr);
      end
      if (done_ok || done_to) begin
        if (gnt == GNT_I) imem_rdata_q <= done_data;
        else              dmem_rdata_q <= done_data;
        err_q <= done_to;
      end
    end
  end

  assign bus_addr   = cmd.addr;
  assign bus_wdata  = cmd.wdata;
  assign bus_sel    = cmd.sel;
  assign bus_we     = cmd.we;
  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;
  assign bus_err    = err_q;

  // Freeze the core while a request is up and not being acknowledged this cycle
  assign stall = (imem_req || dmem_read || dmem_write) && !(imem_ack || dmem_ack);

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Randomised bench for t02_mem_arbiter with a memory-backed bus slave and a
// transaction-level expectation model (latency/error/data from the arbitration rules).
module tb_t02_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, dmem_read, dmem_write, bus_ack;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, bus_rdata;
  logic [3:0]  dmem_sel;
  logic [31:0] imem_rdata, dmem_rdata, bus_addr, bus_wdata;
  logic        imem_ack, dmem_ack, bus_req, bus_we, stall, bus_err;
  logic [3:0]  bus_sel;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [16];
  logic [31:0] exp_mem   [16];

  t02_mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_sel(dmem_sel), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic drop_reqs();
    imem_req = 0; dmem_read = 0; dmem_write = 0;
  endtask

  // Slave-side write with byte enables, as a real memory would apply it
  task automatic slave_write();
    for (int i = 0; i < 4; i++)
      if (bus_sel[i]) slave_mem[bus_addr[5:2]][8*i +: 8] = bus_wdata[8*i +: 8];
  endtask

  // Runs one request from IDLE; the slave acks in BUSY cycle d+1 (never if d is large).
  // Returns observations only; callers compare them against their own expectations.
  task automatic do_txn(input logic ir, input logic dr, input logic dw,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                        input logic [3:0] sl, input int d, input bit scramble,
                        output int ack_k, output logic got_d, output logic err,
                        output logic [31:0] rd, output int nreq,
                        output logic [31:0] g_addr, output logic [31:0] g_wd,
                        output logic [3:0] g_sel, output logic g_we,
                        output bit stall_ok, output bit stable);
    int b;
    bit done;
    imem_req = ir; imem_addr = ia; dmem_read = dr; dmem_write = dw;
    dmem_addr = da; dmem_wdata = wd; dmem_sel = sl;
    ack_k = -1; got_d = 0; err = 0; rd = 0; nreq = 0; g_addr = 0; g_wd = 0; g_sel = 0;
    g_we = 0; stall_ok = 1; stable = 1; b = 0; done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        b++; nreq++;
        if (b == 1) begin
          g_addr = bus_addr; g_wd = bus_wdata; g_sel = bus_sel; g_we = bus_we;
        end else if (bus_addr !== g_addr || bus_wdata !== g_wd || bus_sel !== g_sel || bus_we !== g_we)
          stable = 0;
      end
      if (imem_ack || dmem_ack) begin
        ack_k = k; got_d = dmem_ack; err = bus_err;
        rd = dmem_ack ? dmem_rdata : imem_rdata;
        if (stall !== 1'b0) stall_ok = 0;
        drop_reqs(); bus_ack = 0; done = 1;
      end else begin
        if (stall !== 1'b1) stall_ok = 0;
        if (scramble) begin dmem_addr = $urandom; dmem_wdata = $urandom; end
        if (bus_req && b == d + 1) begin
          bus_ack = 1;
          if (bus_we) begin slave_write(); bus_rdata = $urandom; end
          else bus_rdata = slave_mem[bus_addr[5:2]];
        end else begin
          bus_ack = 0; bus_rdata = $urandom;
        end
      end
    end
    drop_reqs(); bus_ack = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; drop_reqs(); bus_ack = 0; bus_rdata = 0;
    imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel, imem_ack, dmem_ack, bus_err} !== '0) begin
      errors++; $display("FAIL reset_bus got req=%b we=%b addr=%h wd=%h sel=%h ia=%b da=%b err=%b exp all 0",
                         bus_req, bus_we, bus_addr, bus_wdata, bus_sel, imem_ack, dmem_ack, bus_err); end
    checks++; if ({imem_rdata, dmem_rdata, stall} !== '0) begin
      errors++; $display("FAIL reset_rdata got i=%h d=%h stall=%b exp 0", imem_rdata, dmem_rdata, stall); end
    rst = 0;
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_idle got bus_req=%b exp 0", bus_req); end
  endtask

  task automatic test_fetch();
    int ack_k, nreq; logic got_d, err, g_we; logic [31:0] rd, g_addr, g_wd; logic [3:0] g_sel; bit s_ok, st;
    slave_mem[0] = 32'h0010_0093;
    do_txn(1, 0, 0, 32'h0000_0100, 0, 0, 0, 0, 0, ack_k, got_d, err, rd, nreq, g_addr, g_wd, g_sel, g_we, s_ok, st);
    checks++; if (ack_k !== 2) begin errors++; $display("FAIL fetch_latency got %0d exp 2", ack_k); end
    checks++; if (got_d !== 1'b0) begin errors++; $display("FAIL fetch_which got dmem_ack=%b exp 0", got_d); end
    checks++; if (rd !== 32'h0010_0093) begin errors++; $display("FAIL fetch_rdata got %h exp 00100093", rd); end
    checks++; if ({g_we, g_sel, g_addr} !== {1'b0, 4'hF, 32'h100}) begin
      errors++; $display("FAIL fetch_bus got we=%b sel=%h addr=%h exp 0 f 00000100", g_we, g_sel, g_addr); end
    checks++; if (!s_ok) begin errors++; $display("FAIL fetch_stall got bad stall profile exp high until ack"); end
  endtask

  task automatic test_priority();
    logic rq [1:6]; logic we [1:6]; logic [3:0] sel [1:6]; logic [31:0] ad [1:6], wdv [1:6];
    logic ia [1:6]; logic da [1:6]; logic [31:0] irdv, drdv;
    slave_mem[1] = 32'h1234_5678;
    imem_req = 1; imem_addr = 32'h104;
    dmem_write = 1; dmem_addr = 32'h2000; dmem_wdata = 32'hDEAD_BEEF; dmem_sel = 4'b0011;
    irdv = 0; drdv = 32'hFFFF_FFFF;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      rq[k] = bus_req; we[k] = bus_we; sel[k] = bus_sel; ad[k] = bus_addr; wdv[k] = bus_wdata;
      ia[k] = imem_ack; da[k] = dmem_ack;
      if (dmem_ack) begin dmem_write = 0; drdv = dmem_rdata; end
      if (imem_ack) begin imem_req = 0; irdv = imem_rdata; end
      bus_ack = bus_req;
      bus_rdata = bus_req ? slave_mem[bus_addr[5:2]] : $urandom;
    end
    bus_ack = 0;
    checks++; if ({rq[1], we[1], sel[1], ad[1], wdv[1]} !== {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL prio_data_first got req=%b we=%b sel=%b addr=%h wd=%h exp 1 1 0011 00002000 deadbeef",
                         rq[1], we[1], sel[1], ad[1], wdv[1]); end
    checks++; if ({da[2], ia[2], rq[3]} !== 3'b100) begin
      errors++; $display("FAIL prio_data_ack got dack=%b iack=%b req3=%b exp 1 0 0", da[2], ia[2], rq[3]); end
    checks++; if ({rq[4], we[4], sel[4], ad[4]} !== {1'b1, 1'b0, 4'hF, 32'h104}) begin
      errors++; $display("FAIL prio_fetch_grant got req=%b we=%b sel=%h addr=%h exp 1 0 f 00000104",
                         rq[4], we[4], sel[4], ad[4]); end
    checks++; if ({ia[5], irdv, drdv} !== {1'b1, 32'h1234_5678, 32'h0}) begin
      errors++; $display("FAIL prio_fetch_ack got iack5=%b irdata=%h drdata=%h exp 1 12345678 0", ia[5], irdv, drdv); end
  endtask

  task automatic test_timeout();
    int ack_k, nreq; logic got_d, err, g_we; logic [31:0] rd, g_addr, g_wd; logic [3:0] g_sel; bit s_ok, st;
    do_txn(0, 1, 0, 0, 32'h40, 0, 4'hF, 1000, 0, ack_k, got_d, err, rd, nreq, g_addr, g_wd, g_sel, g_we, s_ok, st);
    checks++; if (nreq !== 16) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 16", nreq); end
    checks++; if ({ack_k == 17, got_d, err, rd} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL timeout_resp got k=%0d dack=%b err=%b rd=%h exp 17 1 1 0", ack_k, got_d, err, rd); end
  endtask

  task automatic test_illegal();
    int ack_k, nreq; logic got_d, err, g_we; logic [31:0] rd, g_addr, g_wd; logic [3:0] g_sel; bit s_ok, st;
    do_txn(0, 1, 1, 0, 32'h44, 32'h55, 4'hF, 0, 0, ack_k, got_d, err, rd, nreq, g_addr, g_wd, g_sel, g_we, s_ok, st);
    checks++; if (nreq !== 0) begin errors++; $display("FAIL illegal_no_bus got %0d exp 0", nreq); end
    checks++; if ({ack_k == 1, got_d, err, rd} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL illegal_resp got k=%0d dack=%b err=%b rd=%h exp 1 1 1 0", ack_k, got_d, err, rd); end
  endtask

  task automatic test_wait_states();
    int ack_k, nreq; logic got_d, err, g_we; logic [31:0] rd, g_addr, g_wd; logic [3:0] g_sel; bit s_ok, st;
    slave_mem[15] = 32'hCAFE_F00D;
    do_txn(0, 1, 0, 0, 32'h3C, 0, 4'hF, 5, 1, ack_k, got_d, err, rd, nreq, g_addr, g_wd, g_sel, g_we, s_ok, st);
    checks++; if (!st || g_addr !== 32'h3C) begin
      errors++; $display("FAIL wait_addr_stable got stable=%b addr=%h exp 1 0000003c", st, g_addr); end
    checks++; if ({ack_k == 7, nreq == 6, got_d, err, rd} !== {1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL wait_resp got k=%0d n=%0d dack=%b err=%b rd=%h exp 7 6 1 0 cafef00d",
                         ack_k, nreq, got_d, err, rd); end
  endtask

  task automatic test_reset_busy();
    bit quiet;
    imem_req = 1; imem_addr = 32'h80; bus_ack = 0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1; drop_reqs();
    @(posedge clk); #1;
    checks++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel, imem_ack, dmem_ack, bus_err, imem_rdata, dmem_rdata} !== '0) begin
      errors++; $display("FAIL rstbusy_outputs got req=%b addr=%h sel=%h ird=%h drd=%h exp all 0",
                         bus_req, bus_addr, bus_sel, imem_rdata, dmem_rdata); end
    rst = 0;
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    quiet = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus_ack = 0;
      if ({bus_req, imem_ack, dmem_ack, bus_err} !== 4'b0 || imem_rdata !== 32'h0) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rstbusy_late_ack got activity after late ack exp none"); end
  endtask

  task automatic test_random();
    int ack_k, nreq; logic got_d, err, g_we; logic [31:0] rd, g_addr, g_wd; logic [3:0] g_sel; bit s_ok, st;
    logic [31:0] last_i, last_d, r, ia, da, wd, tgt, e_rd; logic [3:0] sl, w; logic ir, dr, dw, e_err;
    int typ, d, e_n;
    last_i = 0; last_d = 0;
    for (int i = 0; i < 16; i++) begin slave_mem[i] = $urandom; exp_mem[i] = slave_mem[i]; end
    for (int t = 0; t < 40; t++) begin
      typ = $urandom_range(0, 4);
      ir = (typ == 0 || typ == 3 || (typ == 4 && $urandom_range(0, 1) == 1));
      dr = (typ == 1 || typ == 3 || typ == 4);
      dw = (typ == 2 || typ == 4);
      r = $urandom; w = 4'($urandom_range(0, 15)); ia = {r[31:6], w, 2'b00};
      r = $urandom; w = 4'($urandom_range(0, 15)); da = {r[31:6], w, 2'b00};
      wd = $urandom; sl = 4'($urandom_range(1, 15));
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
      do_txn(ir, dr, dw, ia, da, wd, sl, d, 0, ack_k, got_d, err, rd, nreq, g_addr, g_wd, g_sel, g_we, s_ok, st);
      if (dr && dw) begin
        e_n = 0; e_err = 1; e_rd = 0; last_d = 0;
      end else begin
        e_n = 1 + ((d < 15) ? d : 15);
        e_err = (d > 15);
        tgt = (dr || dw) ? da : ia;
        e_rd = (e_err || dw) ? 32'h0 : exp_mem[tgt[5:2]];
        if (dw && !e_err)
          for (int i = 0; i < 4; i++) if (sl[i]) exp_mem[tgt[5:2]][8*i +: 8] = wd[8*i +: 8];
        if (dr || dw) last_d = e_rd; else last_i = e_rd;
        checks++; if ({g_addr, g_sel, g_we} !== {tgt, ((dr || dw) ? sl : 4'hF), dw}) begin
          errors++; $display("FAIL rnd_bus_cmd t=%0d got addr=%h sel=%h we=%b exp %h %h %b",
                             t, g_addr, g_sel, g_we, tgt, ((dr || dw) ? sl : 4'hF), dw); end
        if (dw) begin
          checks++; if (g_wd !== wd) begin errors++; $display("FAIL rnd_wdata t=%0d got %h exp %h", t, g_wd, wd); end
        end
      end
      checks++; if (ack_k !== e_n + 1 || nreq !== e_n) begin
        errors++; $display("FAIL rnd_timing t=%0d got k=%0d n=%0d exp %0d %0d", t, ack_k, nreq, e_n + 1, e_n); end
      checks++; if ({got_d, err, rd} !== {(dr || dw), e_err, e_rd}) begin
        errors++; $display("FAIL rnd_resp t=%0d got dack=%b err=%b rd=%h exp %b %b %h",
                           t, got_d, err, rd, (dr || dw), e_err, e_rd); end
      checks++; if (!s_ok) begin errors++; $display("FAIL rnd_stall t=%0d got bad stall profile exp high until ack", t); end
      checks++; if (imem_rdata !== last_i || dmem_rdata !== last_d) begin
        errors++; $display("FAIL rnd_hold t=%0d got i=%h d=%h exp %h %h", t, imem_rdata, dmem_rdata, last_i, last_d); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_timeout();
    test_illegal();
    test_wait_states();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t02_mem_arbiter.md
# t02_mem_arbiter

Sequences the CPU's single external memory port between instruction fetch and data load/store. Sits between the fetch/decode path (which raises `memRead`/`memWrite`) and the one bus master port to SRAM/Wishbone. It latches each request, drives one bus transaction at a time, and returns a one-cycle acknowledge with registered read data. It also raises `stall` to freeze the PC/register file while any access is outstanding.

## Interface
- `TIMEOUT`, 16, bus cycles to wait for `bus_ack` before aborting; must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  in  1  fetch request; level, held until `imem_ack`.
- `imem_addr`  in  32  fetch address.
- `imem_rdata`  out  32  fetched instruction; valid with `imem_ack`.
- `imem_ack`  out  1  one-cycle fetch done pulse.
- `dmem_read`  in  1  load request (decoder `memRead`); level.
- `dmem_write`  in  1  store request (decoder `memWrite`); level.
- `dmem_addr`  in  32  data address (ALU result).
- `dmem_wdata`  in  32  store data.
- `dmem_sel`  in  4  byte enables (LB/LH/LW, SB/SH/SW).
- `dmem_rdata`  out  32  load data; valid with `dmem_ack`.
- `dmem_ack`  out  1  one-cycle data done pulse.
- `bus_req`, `bus_we`  out  1 each  bus cycle strobe and write enable.
- `bus_addr`, `bus_wdata`  out  32 each  latched address and write data.
- `bus_sel`  out  4  latched byte enables (`4'hF` for fetch).
- `bus_rdata`  in  32  bus read data.
- `bus_ack`  in  1  bus completion.
- `stall`  out  1  CPU freeze.
- `bus_err`  out  1  one-cycle pulse on timeout or illegal request.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - `dmem_read` & `dmem_write` both high: illegal. Pulse `bus_err` and `dmem_ack` with `dmem_rdata`=0. No bus cycle. Go to RESP.
  - Else any data request: grant data. Latch addr, wdata, sel, we=`dmem_write`. Go to BUSY.
  - Else `imem_req`: grant fetch. Latch addr, sel=`4'hF`, we=0. Go to BUSY.
  - Data has strict priority over fetch: the pending load/store belongs to the instruction being executed.
- BUSY:
  - `bus_req`=1 and all bus outputs stay constant.
  - On `bus_ack`: capture `bus_rdata` (writes capture 0) into the granted requester's rdata register. Go to RESP.
  - Timeout counter reaches `TIMEOUT` without `bus_ack`: rdata=0, pulse `bus_err`. Go to RESP.
- RESP:
  - Pulse the granted requester's ack. Return to IDLE.
  - No new grant is made in RESP; the requester drops its request in this cycle.
- rdata registers hold their value until the next completion.
- `stall` = (`imem_req`|`dmem_read`|`dmem_write`) & ~(`imem_ack`|`dmem_ack`).
- Reset (any state, including mid-BUSY):
  - Return to IDLE.
  - Outputs: `bus_req`=0, `bus_we`=0, addr/wdata/rdata=0, `bus_sel`=0, acks=0, `bus_err`=0, timeout counter=0.
  - Any in-flight transaction is abandoned; a late `bus_ack` in IDLE is ignored.

## Timing
- Request sampled in IDLE at cycle N → `bus_req` high at N+1.
- `bus_ack` at cycle M ≥ N+1 → `bus_req` low and requester ack high at M+1.
- Minimum latency is 2 cycles, request to ack.
- Earliest next grant: M+2.
- Timeout counter:
  - Cleared on entering BUSY; increments each BUSY cycle.
  - Abort occurs on the cycle the count equals `TIMEOUT`-1 with no ack.
  - `bus_ack` arriving in that same cycle wins: normal completion, no error.
- `bus_ack` outside BUSY is ignored.
- Request signals are level-sensitive; changes to address/data after grant have no effect until the next grant.

## Structure
- `t02_pkg`:
  - `arb_state_t` (IDLE/BUSY/RESP).
  - `grant_t` (GNT_NONE/GNT_I/GNT_D).
  - `SEL_WORD` = `4'hF`.
- Sub-module `t02_bus_timer`: clear/enable inputs, `expired` output, `TIMEOUT` parameter.

## Test plan
- Fetch only: `imem_req`, addr `0x0000_0100`, bus acks 1 cycle after `bus_req` with `0x0010_0093` → `imem_ack` 2 cycles after request, `imem_rdata`=`0x0010_0093`, `bus_we`=0, `bus_sel`=F, `stall` high until the ack cycle.
- Simultaneous `imem_req` and `dmem_write` (addr `0x2000`, data `0xDEADBEEF`, sel `4'b0011`) → data granted first with `bus_we`=1 and sel `0011`; fetch granted at M+2.
- Timeout: `TIMEOUT`=16, `bus_ack` never arrives → `bus_req` high exactly 16 cycles, then `bus_err` and `dmem_ack` pulse together with `dmem_rdata`=0.
- Illegal: `dmem_read` & `dmem_write` high together → no `bus_req`; `bus_err` + `dmem_ack` in the next cycle.
- Reset in BUSY, then `bus_ack` arrives 2 cycles later → outputs reach reset values the cycle after `rst`; no ack pulses; FSM stays IDLE.
- Wait states: `bus_ack` delayed 5 cycles while `dmem_addr` is changed mid-access → `bus_addr` stays at the latched value throughout; `dmem_ack` at M+1.
